// File: rtl/fila_pkg.sv
// Shared types, defaults and pointer helper for the fila circular FIFO.
package fila_pkg;

  localparam int unsigned FILA_WIDTH = 8;
  localparam int unsigned FILA_DEPTH = 8;

  // Decoded view of the accepted requests for one clock edge
  typedef enum logic [1:0] {
    OP_IDLE = 2'd0,
    OP_ENQ  = 2'd1,
    OP_DEQ  = 2'd2,
    OP_BOTH = 2'd3
  } fila_op_t;

  // Advance a pointer with explicit wrap so any depth works, not just powers of two
  function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
    return (ptr >= depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/fila_if.sv
// Request/status bundle between a producer/consumer and the fila FIFO.
interface fila_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) ();

  localparam int unsigned LEN_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_in;
  logic             enqueue_in;
  logic             dequeue_in;
  logic             clear_in;
  logic [WIDTH-1:0] data_out;
  logic             valid_out;
  logic [LEN_W-1:0] len_out;
  logic             empty_out;
  logic             full_out;
  logic             almost_full_out;
  logic             overflow_out;
  logic             underflow_out;

  modport master (
    output data_in, enqueue_in, dequeue_in, clear_in,
    input  data_out, valid_out, len_out, empty_out, full_out,
           almost_full_out, overflow_out, underflow_out
  );

  modport slave (
    input  data_in, enqueue_in, dequeue_in, clear_in,
    output data_out, valid_out, len_out, empty_out, full_out,
           almost_full_out, overflow_out, underflow_out
  );

endinterface

// File: rtl/fila_mem.sv
// DEPTH x WIDTH storage: one synchronous write port, one combinational read port.
module fila_mem #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = 3
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [PTR_W-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port; contents need no reset since len gates every read
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fila_param.sv
// Parametrised circular-buffer FIFO with status flags, sticky errors and flush.
module fila_param
  import fila_pkg::*;
#(
  parameter int unsigned WIDTH    = FILA_WIDTH,
  parameter int unsigned DEPTH    = FILA_DEPTH,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned LEN_W    = $clog2(DEPTH + 1)
) (
  input  logic clk_10KHz,
  input  logic reset,
  fila_if.slave bus
);

  localparam int unsigned PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LEN_W-1:0] len_q;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             ovf_q;
  logic             unf_q;

  logic             full_c;
  logic             empty_c;
  logic             enq_ok;
  logic             deq_ok;
  logic             ovf_evt;
  logic             unf_evt;
  fila_op_t         op;
  logic [WIDTH-1:0] rd_data;

  // Acceptance decode against pre-edge occupancy; a dequeue frees the slot a full enqueue needs
  always_comb begin
    full_c  = (len_q == LEN_W'(DEPTH));
    empty_c = (len_q == '0);
    enq_ok  = bus.enqueue_in && (!full_c || bus.dequeue_in);
    deq_ok  = bus.dequeue_in && !empty_c;
    ovf_evt = bus.enqueue_in && !enq_ok;
    unf_evt = bus.dequeue_in && !deq_ok;
    op      = OP_IDLE;
    case ({enq_ok, deq_ok})
      2'b10:   op = OP_ENQ;
      2'b01:   op = OP_DEQ;
      2'b11:   op = OP_BOTH;
      default: op = OP_IDLE;
    endcase
  end

  fila_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk     (clk_10KHz),
    .wr_en   (enq_ok && !bus.clear_in),
    .wr_addr (wr_ptr),
    .wr_data (bus.data_in),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  // Pointers, occupancy, output register and sticky flags; flush overrides requests
  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      len_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else if (bus.clear_in) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      len_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (op == OP_ENQ || op == OP_BOTH) begin
        wr_ptr <= PTR_W'(next_ptr(32'(wr_ptr), DEPTH));
      end
      if (op == OP_DEQ || op == OP_BOTH) begin
        rd_ptr  <= PTR_W'(next_ptr(32'(rd_ptr), DEPTH));
        data_q  <= rd_data;
        valid_q <= 1'b1;
      end
      case (op)
        OP_ENQ:  len_q <= len_q + LEN_W'(1);
        OP_DEQ:  len_q <= len_q - LEN_W'(1);
        default: len_q <= len_q;
      endcase
      if (ovf_evt) begin
        ovf_q <= 1'b1;
      end
      if (unf_evt) begin
        unf_q <= 1'b1;
      end
    end
  end

  assign bus.data_out        = data_q;
  assign bus.valid_out       = valid_q;
  assign bus.len_out         = len_q;
  assign bus.empty_out       = (len_q == '0);
  assign bus.full_out        = (len_q == LEN_W'(DEPTH));
  assign bus.almost_full_out = (len_q >= LEN_W'(AF_LEVEL));
  assign bus.overflow_out    = ovf_q;
  assign bus.underflow_out   = unf_q;

endmodule

// File: tb/tb_fila_param.sv
// Self-checking bench for fila_param: vector table on an 8x8 instance, scoreboard on a 5x12 one.
module tb_fila_param;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fila_if #(.WIDTH(8),  .DEPTH(8)) ba ();
  fila_if #(.WIDTH(12), .DEPTH(5)) bb ();

  fila_param #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6)) dut_a (
    .clk_10KHz (clk),
    .reset     (rst),
    .bus       (ba)
  );

  fila_param #(.WIDTH(12), .DEPTH(5)) dut_b (
    .clk_10KHz (clk),
    .reset     (rst),
    .bus       (bb)
  );

  typedef struct {
    logic       enq;
    logic       deq;
    logic       clr;
    logic [7:0] din;
    int         len;
    logic       valid;
    logic [7:0] dout;
    logic       ovf;
    logic       unf;
  } vec_t;

  vec_t        vecs[$];
  logic [7:0]  sb_a[$];
  logic [11:0] sb_b[$];
  logic [11:0] mq[$];
  logic [11:0] m_dout;
  logic        m_ovf;
  logic        m_unf;
  int          checks   = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] pk(input logic v, input logic e, input logic f,
                                    input logic af, input logic o, input logic u);
    return {v, e, f, af, o, u};
  endfunction

  function automatic void add(input logic enq, input logic deq, input logic clr, input logic [7:0] din,
                              input int len, input logic valid, input logic [7:0] dout,
                              input logic ovf, input logic unf);
    vec_t v;
    v.enq = enq; v.deq = deq; v.clr = clr; v.din = din; v.len = len;
    v.valid = valid; v.dout = dout; v.ovf = ovf; v.unf = unf;
    vecs.push_back(v);
  endfunction

  task automatic check_a_state(input string tag, input int len, input logic valid,
                               input logic [7:0] dout, input logic ovf, input logic unf);
    check({tag, "_len"}, 32'(ba.len_out), 32'(len));
    check({tag, "_flags"},
          32'(pk(ba.valid_out, ba.empty_out, ba.full_out, ba.almost_full_out, ba.overflow_out, ba.underflow_out)),
          32'(pk(valid, len == 0, len == 8, len >= 6, ovf, unf)));
    check({tag, "_data"}, 32'(ba.data_out), 32'(dout));
  endtask

  // One cycle on the 5-deep instance with a reference queue predicting the result
  task automatic step_b(input logic enq, input logic deq, input logic clr, input logic [11:0] din);
    logic deq_ok, enq_ok, exp_valid;
    @(negedge clk);
    bb.enqueue_in = enq;
    bb.dequeue_in = deq;
    bb.clear_in   = clr;
    bb.data_in    = din;
    exp_valid = 1'b0;
    if (clr) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      deq_ok = deq && (mq.size() > 0);
      enq_ok = enq && ((mq.size() < 5) || deq);
      if (enq && !enq_ok) m_ovf = 1'b1;
      if (deq && !deq_ok) m_unf = 1'b1;
      if (deq_ok) begin
        m_dout = mq.pop_front();
        sb_b.push_back(m_dout);
        exp_valid = 1'b1;
      end
      if (enq_ok) mq.push_back(din);
    end
    @(posedge clk);
    #1;
    check("b_len", 32'(bb.len_out), 32'(mq.size()));
    check("b_flags",
          32'(pk(bb.valid_out, bb.empty_out, bb.full_out, bb.almost_full_out, bb.overflow_out, bb.underflow_out)),
          32'(pk(exp_valid, mq.size() == 0, mq.size() == 5, mq.size() >= 3, m_ovf, m_unf)));
    check("b_hold", 32'(bb.data_out), 32'(m_dout));
    if (bb.valid_out) begin
      if (sb_b.size() == 0) check("b_sb_empty", 32'(bb.data_out), 32'hDEAD_BEEF);
      else                  check("b_sb", 32'(bb.data_out), 32'(sb_b.pop_front()));
    end
  endtask

  initial begin
    rst = 1'b1;
    ba.data_in = '0; ba.enqueue_in = 1'b0; ba.dequeue_in = 1'b0; ba.clear_in = 1'b0;
    bb.data_in = '0; bb.enqueue_in = 1'b0; bb.dequeue_in = 1'b0; bb.clear_in = 1'b0;
    m_dout = '0; m_ovf = 1'b0; m_unf = 1'b0;

    // Fill, overflow, drain, underflow, flush, wrap with same-cycle enq+deq, empty enq+deq
    for (int k = 1; k <= 8; k++) add(1, 0, 0, 8'(16 + k), k, 0, 8'h00, 0, 0);
    add(1, 0, 0, 8'h99, 8, 0, 8'h00, 1, 0);
    for (int k = 1; k <= 8; k++) add(0, 1, 0, 8'h00, 8 - k, 1, 8'(16 + k), 1, 0);
    add(0, 1, 0, 8'h00, 0, 0, 8'h18, 1, 1);
    add(0, 0, 1, 8'h00, 0, 0, 8'h18, 0, 0);
    for (int k = 1; k <= 8; k++) add(1, 0, 0, 8'(16 + k), k, 0, 8'h18, 0, 0);
    add(1, 1, 0, 8'hA0, 8, 1, 8'h11, 0, 0);
    for (int k = 2; k <= 8; k++) add(0, 1, 0, 8'h00, 9 - k, 1, 8'(16 + k), 0, 0);
    add(0, 1, 0, 8'h00, 0, 1, 8'hA0, 0, 0);
    add(1, 1, 0, 8'h55, 1, 0, 8'hA0, 0, 1);
    add(0, 1, 0, 8'h00, 0, 1, 8'h55, 0, 1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_a_state("a_reset", 0, 0, 8'h00, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      ba.enqueue_in = vecs[i].enq;
      ba.dequeue_in = vecs[i].deq;
      ba.clear_in   = vecs[i].clr;
      ba.data_in    = vecs[i].din;
      if (vecs[i].valid) sb_a.push_back(vecs[i].dout);
      @(posedge clk);
      #1;
      check_a_state($sformatf("a_vec%0d", i), vecs[i].len, vecs[i].valid, vecs[i].dout,
                    vecs[i].ovf, vecs[i].unf);
      if (ba.valid_out) begin
        if (sb_a.size() == 0) check("a_sb_empty", 32'(ba.data_out), 32'hDEAD_BEEF);
        else                  check("a_sb", 32'(ba.data_out), 32'(sb_a.pop_front()));
      end
    end
    check("a_sb_left", 32'(sb_a.size()), 32'd0);

    // Mid-stream asynchronous reset with 4 entries held
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      ba.enqueue_in = 1'b1;
      ba.dequeue_in = 1'b0;
      ba.data_in    = 8'(48 + k);
      @(posedge clk);
      #1;
      check_a_state($sformatf("a_pre%0d", k), k, 0, 8'h55, 0, 1);
    end
    @(negedge clk);
    ba.enqueue_in = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_a_state("a_async_rst", 0, 0, 8'h00, 0, 0);
    #1;
    rst = 1'b0;

    // 5-deep, 12-bit: 7 enqueues with 2 refused, then order across the wrap point
    for (int k = 0; k < 7; k++) begin
      step_b(1, 0, 0, 12'(12'hA01 + k));
      if (k == 4) check("b_ovf_at5", 32'(bb.overflow_out), 32'd0);
    end
    check("b_ovf_sticky", 32'(bb.overflow_out), 32'd1);
    check("b_len_full", 32'(bb.len_out), 32'd5);
    for (int k = 0; k < 3; k++) step_b(0, 1, 0, 12'h000);
    for (int k = 0; k < 3; k++) step_b(1, 0, 0, 12'(12'hB01 + k));
    for (int k = 0; k < 6; k++) step_b(0, 1, 0, 12'h000);
    check("b_last", 32'(bb.data_out), 32'hB03);
    check("b_unf", 32'(bb.underflow_out), 32'd1);

    // Random traffic with occasional flush
    for (int k = 0; k < 300; k++) begin
      step_b(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45),
             1'($urandom_range(0, 99) < 3), 12'($urandom));
    end
    check("b_sb_left", 32'(sb_b.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fila_param.md
Name: fila_param

Overview:
- Parametrised circular-buffer FIFO; next generation of the team's 8x8 shift-register queue.
- Generalised in data width, depth and almost-full threshold.
- Adds same-cycle enqueue+dequeue, full/empty/almost-full status, sticky overflow/underflow errors, a synchronous flush and a read-valid strobe.
- Sits between producer logic and slow consumers (display/serial) in the 10 kHz domain.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 8, number of entries (>=2; need not be a power of two).
- AF_LEVEL, DEPTH-2, occupancy at or above which almost_full_out asserts (1..DEPTH).
- LEN_W, $clog2(DEPTH+1), width of the occupancy count (derived; do not override).

Ports:
- clk_10KHz  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- data_in  in  WIDTH  word to enqueue.
- enqueue_in  in  1  enqueue request, sampled each rising edge.
- dequeue_in  in  1  dequeue request, sampled each rising edge.
- clear_in  in  1  synchronous flush.
- data_out  out  WIDTH  last dequeued word (registered).
- valid_out  out  1  one-cycle pulse: data_out was updated this cycle.
- len_out  out  LEN_W  current occupancy, 0..DEPTH.
- empty_out  out  1  len_out==0.
- full_out  out  1  len_out==DEPTH.
- almost_full_out  out  1  len_out>=AF_LEVEL.
- overflow_out  out  1  sticky: an enqueue was refused.
- underflow_out  out  1  sticky: a dequeue was refused.

Behaviour:
- Reset (async, any time, including mid-operation): wr_ptr=rd_ptr=0, len_out=0, data_out=0, valid_out=0, overflow_out=0, underflow_out=0. Storage contents are don't-care.
- Reset outputs: empty_out=1, full_out=0, almost_full_out=(AF_LEVEL==0 ? 1 : 0), i.e. 0 for legal values.
- Storage: DEPTH x WIDTH array. wr_ptr and rd_ptr wrap explicitly from DEPTH-1 to 0, with no power-of-two assumption.
- Acceptance (evaluated against state before the edge):
  - enq_ok = enqueue_in && (!full || dequeue_in).
  - deq_ok = dequeue_in && !empty.
- Enqueue accept: mem[wr_ptr] <= data_in; wr_ptr advances.
- Dequeue accept: data_out <= mem[rd_ptr]; rd_ptr advances; valid_out=1 next cycle. Latency is 1 cycle from request edge to data_out/valid_out.
- Without an accepted dequeue: valid_out=0 and data_out holds its value.
- len_out update: +1 if enq_ok only; -1 if deq_ok only; unchanged if both or neither.
- Simultaneous enq+deq when full: both accepted; len stays DEPTH; no overflow.
- Simultaneous enq+deq when empty: enqueue accepted; dequeue refused; underflow_out set; len becomes 1. No fall-through: the new word is not presented to data_out.
- Refused enqueue (full, no dequeue): data dropped; overflow_out set.
- Refused dequeue (empty): data_out holds; valid_out=0; underflow_out set.
- Sticky flags stay set until reset or clear_in.
- clear_in has priority over enqueue_in and dequeue_in in the same cycle:
  - pointers=0, len=0, valid_out=0, both sticky flags cleared.
  - data_out holds its value.
- Status flags are combinational from len_out (registered), so they are glitch-free relative to the clock.
- Arithmetic: len_out in LEN_W bits never exceeds DEPTH and never wraps below 0. Pointers are $clog2(DEPTH) bits, minimum 1.

Decomposition:
- Package fila_pkg:
  - default localparams FILA_WIDTH=8, FILA_DEPTH=8.
  - typedef enum {OP_IDLE, OP_ENQ, OP_DEQ, OP_BOTH} fila_op_t, used to decode requests.
  - function next_ptr(ptr, depth) implementing the explicit wrap.
- Sub-module fila_mem: DEPTH x WIDTH storage, one synchronous write port, one combinational read port. Reset-free.
- Control (pointers, count, flags, output register) stays in fila_param.

Test Plan (WIDTH=8, DEPTH=8, AF_LEVEL=6 unless stated):
- Reset, then enqueue 0x11..0x18 on 8 consecutive cycles -> len 1..8. almost_full_out rises on the cycle len_out reaches 6; full_out=1 at 8; overflow_out=0.
- From full, enqueue 0x99 -> refused; overflow_out=1; len=8. Then dequeue 8 times -> data_out 0x11..0x18, each with a 1-cycle valid_out pulse; empty_out=1.
- With empty FIFO, dequeue -> valid_out=0, underflow_out=1, data_out holds 0x18. Then clear_in -> both sticky flags 0.
- Fill to 8, then enq 0xA0 + deq on the same cycle -> data_out=0x11, len stays 8. Then drain -> last word 0xA0. This confirms wrap-around across index 7->0.
- Empty FIFO, enq 0x55 + deq on the same cycle -> len=1, underflow_out=1, valid_out=0. Next deq -> data_out=0x55.
- Assert reset mid-stream (len=4) between clock edges -> outputs return to reset values immediately, without waiting for a clock edge. Repeat with DEPTH=5, WIDTH=12: 7 enqueues -> 2 overflows counted via the sticky flag; order preserved across wrap.
